// File: rtl/bf16_div_arbiter.sv
// -----------------------------------------------------------------------------
// bf16_div_arbiter
//
// Round-robin arbiter that shares a single bf16 divider between NUM_REQ
// co-processor requesters. One operand pair is accepted at a time, handed to
// the divider over its STB/BUSY handshake, and the quotient is returned to the
// granted requester with a one-hot result strobe. A watchdog substitutes a
// quiet NaN (16'hFFC0) and raises a sticky error flag if the divider never
// answers.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req_a / req_b    packed dividends / divisors, requester i at [16i+15:16i]
//   req_STB          per-requester request valid
//   req_BUSY         per-requester busy; low only for the requester accepted
//                    this cycle
//   res_z            shared result bus (holds until the next delivery)
//   res_STB          one-hot result valid
//   res_module_BUSY  per-requester "not ready for result"
//   div_a / div_b    operands to the divider
//   div_input_STB    operand strobe to the divider
//   div_BUSY         divider not ready to take operands
//   div_z            quotient from the divider
//   div_output_STB   quotient valid from the divider
//   div_out_BUSY     back-pressure to the divider output
//   err_timeout      sticky watchdog flag
// -----------------------------------------------------------------------------
module bf16_div_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_STB,
  output logic [NUM_REQ-1:0]      req_BUSY,
  output logic [15:0]             res_z,
  output logic [NUM_REQ-1:0]      res_STB,
  input  logic [NUM_REQ-1:0]      res_module_BUSY,
  output logic [15:0]             div_a,
  output logic [15:0]             div_b,
  output logic                    div_input_STB,
  input  logic                    div_BUSY,
  input  logic [15:0]             div_z,
  input  logic                    div_output_STB,
  output logic                    div_out_BUSY,
  output logic                    err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] QNAN = 16'hFFC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DELIVER
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t              state_q,        state_d;
  logic [IDX_W-1:0]    rr_ptr_q,       rr_ptr_d;
  logic [IDX_W-1:0]    grant_q,        grant_d;
  logic [15:0]         div_a_q,        div_a_d;
  logic [15:0]         div_b_q,        div_b_d;
  logic                div_stb_q,      div_stb_d;
  logic                div_out_busy_q, div_out_busy_d;
  logic [15:0]         res_z_q,        res_z_d;
  logic [NUM_REQ-1:0]  res_stb_q,      res_stb_d;
  logic                err_q,          err_d;
  logic [CNT_W-1:0]    cnt_q,          cnt_d;

  // ---------------------------------------------------------------------------
  // Unpacked views of the request buses and the one-hot grant
  // ---------------------------------------------------------------------------
  logic [15:0]        req_a_arr [NUM_REQ];
  logic [15:0]        req_b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] accept_onehot;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               accept_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_a_arr[gi]     = req_a[16*gi +: 16];
      assign req_b_arr[gi]     = req_b[16*gi +: 16];
      assign grant_onehot[gi]  = (grant_q == IDX_W'(gi));
      assign accept_onehot[gi] = accept_en && (winner == IDX_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin winner: first requester at or after rr_ptr (mod NUM_REQ).
  // ---------------------------------------------------------------------------
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      int               sum;
      logic [IDX_W-1:0] cand;
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!found && req_STB[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Acceptance is only possible in IDLE; rst masks it so req_BUSY reads
  // all-ones during reset regardless of what the requesters drive.
  assign accept_en = (state_q == ST_IDLE) && found && !rst;
  assign req_BUSY  = ~accept_onehot;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    div_stb_d      = div_stb_q;
    div_out_busy_d = div_out_busy_q;
    res_z_d        = res_z_q;
    res_stb_d      = res_stb_q;
    err_d          = err_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          div_a_d   = req_a_arr[winner];
          div_b_d   = req_b_arr[winner];
          grant_d   = winner;
          rr_ptr_d  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          div_stb_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The divider may still be leaving its output state; hold the strobe
        // until it reports not busy at an edge.
        if (!div_BUSY) begin
          div_stb_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (div_output_STB) begin
          // Open the output handshake for exactly one cycle.
          div_out_busy_d = 1'b0;
          state_d        = ST_CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          res_z_d   = QNAN;
          err_d     = 1'b1;
          res_stb_d = grant_onehot;
          state_d   = ST_DELIVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        // The divider sees STB && !BUSY at this edge and returns to idle.
        res_z_d        = div_z;
        div_out_busy_d = 1'b1;
        res_stb_d      = grant_onehot;
        state_d        = ST_DELIVER;
      end

      ST_DELIVER: begin
        // Only the granted requester's back-pressure matters.
        if (!res_module_BUSY[grant_q]) begin
          res_stb_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      div_stb_q      <= 1'b0;
      div_out_busy_q <= 1'b1;
      res_z_q        <= '0;
      res_stb_q      <= '0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      div_stb_q      <= div_stb_d;
      div_out_busy_q <= div_out_busy_d;
      res_z_q        <= res_z_d;
      res_stb_q      <= res_stb_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

  assign div_a         = div_a_q;
  assign div_b         = div_b_q;
  assign div_input_STB = div_stb_q;
  assign div_out_BUSY  = div_out_busy_q;
  assign res_z         = res_z_q;
  assign res_STB       = res_stb_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_bf16_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bf16_div_arbiter
//
// Directed bench for bf16_div_arbiter with NUM_REQ=2. A small behavioural
// divider stand-in answers from a table of hand-computed bf16 quotients after
// a programmable latency, or never answers when told to hang.
// -----------------------------------------------------------------------------
module tb_bf16_div_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_stb;
  logic [1:0]  req_busy;
  logic [15:0] res_z;
  logic [1:0]  res_stb;
  logic [1:0]  res_busy;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic        div_input_stb;
  logic        div_busy;
  logic [15:0] div_z;
  logic        div_output_stb;
  logic        div_out_busy;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;

  bf16_div_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .req_b(req_b),
    .req_STB(req_stb),
    .req_BUSY(req_busy),
    .res_z(res_z),
    .res_STB(res_stb),
    .res_module_BUSY(res_busy),
    .div_a(div_a),
    .div_b(div_b),
    .div_input_STB(div_input_stb),
    .div_BUSY(div_busy),
    .div_z(div_z),
    .div_output_STB(div_output_stb),
    .div_out_BUSY(div_out_busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Divider stand-in
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_PUT  = 2'd2;

  logic [1:0]  stub_st;
  int          stub_cnt;
  int          stub_lat;
  logic        stub_hang;
  logic [15:0] stub_z;

  function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h40C0_4000: quot = 16'h4040; // 6.0 / 2.0 = 3.0
      32'h3F80_4000: quot = 16'h3F00; // 1.0 / 2.0 = 0.5
      32'h4040_3F80: quot = 16'h4040; // 3.0 / 1.0 = 3.0
      32'h3F80_0000: quot = 16'h7F80; // 1.0 / 0.0 = +inf
      32'h4000_3F80: quot = 16'h4000; // 2.0 / 1.0 = 2.0
      default:       quot = 16'h7FC0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      stub_st  <= S_IDLE;
      stub_cnt <= 0;
      stub_z   <= 16'h0000;
    end else begin
      case (stub_st)
        S_IDLE: begin
          if (div_input_stb) begin
            stub_z   <= quot(div_a, div_b);
            stub_cnt <= stub_lat;
            stub_st  <= S_CALC;
          end
        end
        S_CALC: begin
          if (stub_cnt <= 1) begin
            if (!stub_hang) stub_st <= S_PUT;
          end else begin
            stub_cnt <= stub_cnt - 1;
          end
        end
        S_PUT: begin
          if (!div_out_busy) stub_st <= S_IDLE;
        end
        default: stub_st <= S_IDLE;
      endcase
    end
  end

  assign div_busy       = (stub_st != S_IDLE);
  assign div_output_stb = (stub_st == S_PUT);
  assign div_z          = stub_z;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_stb[idx]        = 1'b1;
  endtask

  task automatic clr_req(input int idx);
    req_stb[idx] = 1'b0;
  endtask

  // Counts edges until res_STB rises; cycles is the latency from the edge
  // preceding the call.
  task automatic wait_res(input int bound, output int cycles);
    cycles = 0;
    while (cycles < bound) begin
      @(posedge clk);
      #1;
      cycles++;
      if (res_stb != 2'b00) break;
    end
    check_val("res_wait", {31'b0, (res_stb != 2'b00)}, 32'd1);
    $display("txn: res_STB=%b res_z=0x%h latency=%0d err=%0b", res_stb, res_z, cycles, err_timeout);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int seen;

    rst       = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_stb   = '0;
    res_busy  = '0;
    stub_lat  = 6;
    stub_hang = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check_val("rst_res_stb",  {30'b0, res_stb},       32'h0);
    check_val("rst_res_z",    {16'b0, res_z},         32'h0);
    check_val("rst_err",      {31'b0, err_timeout},   32'h0);
    check_val("rst_req_busy", {30'b0, req_busy},      32'h3);
    check_val("rst_div_stb",  {31'b0, div_input_stb}, 32'h0);
    check_val("rst_div_obsy", {31'b0, div_out_busy},  32'h1);
    rst = 1'b0;

    // Single request: 6.0 / 2.0
    set_req(0, 16'h40C0, 16'h4000);
    #1;
    check_val("single_grant", {30'b0, req_busy}, 32'h2);
    @(posedge clk); #1;
    clr_req(0);
    check_val("single_busy_after", {30'b0, req_busy},      32'h3);
    check_val("single_div_a",      {16'b0, div_a},         32'h40C0);
    check_val("single_div_b",      {16'b0, div_b},         32'h4000);
    check_val("single_div_stb",    {31'b0, div_input_stb}, 32'h1);
    wait_res(500, lat);
    check_val("single_latency", lat,               32'd9);
    check_val("single_res_stb", {30'b0, res_stb},  32'h1);
    check_val("single_res_z",   {16'b0, res_z},    32'h4040);
    @(posedge clk); #1;
    check_val("single_stb_drop", {30'b0, res_stb}, 32'h0);
    check_val("single_z_hold",   {16'b0, res_z},   32'h4040);

    // Simultaneous round from reset; req1's result back-pressure is high
    // throughout req0's delivery and must be ignored there.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    res_busy = 2'b10;
    set_req(0, 16'h3F80, 16'h4000);
    set_req(1, 16'h4040, 16'h3F80);
    #1;
    check_val("sim1_grant0", {30'b0, req_busy}, 32'h2);
    @(posedge clk); #1;
    clr_req(0);
    wait_res(500, lat);
    check_val("sim1_r0_stb", {30'b0, res_stb}, 32'h1);
    check_val("sim1_r0_z",   {16'b0, res_z},   32'h3F00);
    @(posedge clk); #1;
    check_val("sim1_r0_done", {30'b0, res_stb},  32'h0);
    check_val("sim1_grant1",  {30'b0, req_busy}, 32'h1);
    @(posedge clk); #1;
    clr_req(1);
    set_req(0, 16'h3F80, 16'h0000);  // pending during back-pressure
    wait_res(500, lat);
    check_val("sim1_r1_stb", {30'b0, res_stb}, 32'h2);
    check_val("sim1_r1_z",   {16'b0, res_z},   32'h4040);

    // Back-pressure on req1 for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_val("bp_res_stb",  {30'b0, res_stb},       32'h2);
      check_val("bp_res_z",    {16'b0, res_z},         32'h4040);
      check_val("bp_req_busy", {30'b0, req_busy},      32'h3);
      check_val("bp_div_stb",  {31'b0, div_input_stb}, 32'h0);
    end
    res_busy = 2'b00;
    @(posedge clk); #1;
    check_val("bp_release_stb", {30'b0, res_stb},  32'h0);
    check_val("bp_next_grant",  {30'b0, req_busy}, 32'h2);

    // Special value: 1.0 / 0.0 = +inf passes through
    @(posedge clk); #1;
    clr_req(0);
    wait_res(500, lat);
    check_val("inf_res_stb", {30'b0, res_stb},     32'h1);
    check_val("inf_res_z",   {16'b0, res_z},       32'h7F80);
    check_val("inf_err",     {31'b0, err_timeout}, 32'h0);
    @(posedge clk); #1;
    check_val("inf_done", {30'b0, res_stb}, 32'h0);

    // Second simultaneous round: pointer now at 1
    set_req(0, 16'h40C0, 16'h4000);
    set_req(1, 16'h3F80, 16'h4000);
    #1;
    check_val("sim2_grant1", {30'b0, req_busy}, 32'h1);
    @(posedge clk); #1;
    clr_req(1);
    wait_res(500, lat);
    check_val("sim2_r1_stb", {30'b0, res_stb}, 32'h2);
    check_val("sim2_r1_z",   {16'b0, res_z},   32'h3F00);
    @(posedge clk); #1;
    check_val("sim2_r1_done", {30'b0, res_stb},  32'h0);
    check_val("sim2_grant0",  {30'b0, req_busy}, 32'h2);
    @(posedge clk); #1;
    clr_req(0);
    wait_res(500, lat);
    check_val("sim2_r0_stb", {30'b0, res_stb}, 32'h1);
    check_val("sim2_r0_z",   {16'b0, res_z},   32'h4040);
    @(posedge clk); #1;
    check_val("sim2_r0_done", {30'b0, res_stb}, 32'h0);

    // Watchdog: divider never answers
    stub_hang = 1'b1;
    set_req(0, 16'h4000, 16'h3F80);
    @(posedge clk); #1;
    clr_req(0);
    wait_res(400, lat);
    check_val("to_latency", lat,                   TIMEOUT + 2);
    check_val("to_res_stb", {30'b0, res_stb},      32'h1);
    check_val("to_res_z",   {16'b0, res_z},        32'hFFC0);
    check_val("to_err",     {31'b0, err_timeout},  32'h1);
    @(posedge clk); #1;
    check_val("to_done", {30'b0, res_stb}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check_val("to_err_sticky", {31'b0, err_timeout}, 32'h1);

    // Reset clears the sticky flag and the held result
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("to_err_cleared", {31'b0, err_timeout}, 32'h0);
    check_val("to_z_cleared",   {16'b0, res_z},       32'h0);

    // Reset in the middle of WAIT
    stub_hang = 1'b0;
    stub_lat  = 40;
    set_req(0, 16'h3F80, 16'h4000);
    @(posedge clk); #1;
    clr_req(0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_res_stb",  {30'b0, res_stb},       32'h0);
    check_val("mid_res_z",    {16'b0, res_z},         32'h0);
    check_val("mid_err",      {31'b0, err_timeout},   32'h0);
    check_val("mid_req_busy", {30'b0, req_busy},      32'h3);
    check_val("mid_div_stb",  {31'b0, div_input_stb}, 32'h0);
    check_val("mid_div_obsy", {31'b0, div_out_busy},  32'h1);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (res_stb != 2'b00) seen++;
    end
    check_val("mid_no_stale_res", seen, 32'd0);

    // Fresh request after the abort
    stub_lat = 5;
    set_req(1, 16'h4040, 16'h3F80);
    #1;
    check_val("post_grant1", {30'b0, req_busy}, 32'h1);
    @(posedge clk); #1;
    clr_req(1);
    wait_res(500, lat);
    check_val("post_latency", lat,              32'd8);
    check_val("post_res_stb", {30'b0, res_stb}, 32'h2);
    check_val("post_res_z",   {16'b0, res_z},   32'h4040);
    @(posedge clk); #1;
    check_val("post_done", {30'b0, res_stb}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
